// File: rtl/command_executor.sv
// Executes the planner's per-node command list: turn or go straight at each node,
// follow the line to the next debounced node, advance the command index, repeat.
module command_executor #(
    parameter int TURN_CYCLES     = 25_000_000,
    parameter int UTURN_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int BLIND_CYCLES    = 500_000,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [2:0] robo_command,
    input  logic       replan,
    input  logic       node_raw,
    output logic [5:0] counter,
    output logic [1:0] turn_dir,
    output logic       line_follow_en,
    output logic       node_pulse,
    output logic       busy,
    output logic       cmd_err
);

    localparam int TMAX = (UTURN_CYCLES > TURN_CYCLES) ? UTURN_CYCLES : TURN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(BLIND_CYCLES + 1);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW   = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {S_STOP, S_TURN, S_FOLLOW, S_ADVANCE} state_t;

    state_t          state_q;
    logic [5:0]      counter_q;
    logic [5:0]      counter_d;
    logic [1:0]      turn_dir_q;
    logic [1:0]      dispatch_dir_d;
    logic            line_follow_en_q;
    logic            node_pulse_q;
    logic            busy_q;
    logic            cmd_err_q;
    logic [TW-1:0]   timer_q;
    logic [BW-1:0]   blind_q;
    logic [SW-1:0]   settle_q;

    logic [1:0]      sync_q;
    logic            deb_q;
    logic            deb_prev_q;
    logic [DW-1:0]   deb_cnt_q;
    logic            node_evt_q;

    // Synchronizer, debouncer and registered rising-edge detector for the node sensor.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b00;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
            node_evt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], node_raw};
            if (sync_q[1] != deb_q) begin
                if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q     <= sync_q[1];
                    deb_cnt_q <= '0;
                end else begin
                    deb_cnt_q <= deb_cnt_q + DW'(1);
                end
            end else begin
                deb_cnt_q <= '0;
            end
            deb_prev_q <= deb_q;
            node_evt_q <= deb_q & ~deb_prev_q;
        end
    end

    assign counter_d = (counter_q == 6'd63) ? counter_q : counter_q + 6'd1;

    always_comb begin
        dispatch_dir_d = 2'b00;
        case (robo_command)
            3'd2:    dispatch_dir_d = 2'b01;
            3'd3:    dispatch_dir_d = 2'b10;
            3'd4:    dispatch_dir_d = 2'b11;
            default: dispatch_dir_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_STOP;
            counter_q        <= '0;
            turn_dir_q       <= 2'b00;
            line_follow_en_q <= 1'b0;
            node_pulse_q     <= 1'b0;
            busy_q           <= 1'b0;
            cmd_err_q        <= 1'b0;
            timer_q          <= '0;
            blind_q          <= '0;
            settle_q         <= '0;
        end else begin
            node_pulse_q <= 1'b0;
            case (state_q)
                S_STOP: begin
                    if (replan) begin
                        counter_q <= '0;
                        settle_q  <= SW'(SETTLE_CYCLES);
                    end else if (settle_q != '0) begin
                        // The planner may still present its old table here.
                        settle_q <= settle_q - SW'(1);
                    end else begin
                        case (robo_command)
                            3'd0: ;
                            3'd1: begin
                                state_q          <= S_FOLLOW;
                                line_follow_en_q <= 1'b1;
                                busy_q           <= 1'b1;
                                blind_q          <= BW'(BLIND_CYCLES);
                            end
                            3'd2, 3'd3, 3'd4: begin
                                state_q    <= S_TURN;
                                busy_q     <= 1'b1;
                                turn_dir_q <= dispatch_dir_d;
                                timer_q    <= (robo_command == 3'd4) ? TW'(UTURN_CYCLES - 1)
                                                                     : TW'(TURN_CYCLES - 1);
                            end
                            default: cmd_err_q <= 1'b1;
                        endcase
                    end
                end
                S_TURN: begin
                    if (timer_q == '0) begin
                        state_q          <= S_FOLLOW;
                        turn_dir_q       <= 2'b00;
                        line_follow_en_q <= 1'b1;
                        blind_q          <= BW'(BLIND_CYCLES);
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_FOLLOW: begin
                    if (blind_q != '0) begin
                        blind_q <= blind_q - BW'(1);
                    end else if (node_evt_q) begin
                        state_q          <= S_ADVANCE;
                        counter_q        <= counter_d;
                        node_pulse_q     <= 1'b1;
                        line_follow_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_STOP;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign counter        = counter_q;
    assign turn_dir       = turn_dir_q;
    assign line_follow_en = line_follow_en_q;
    assign node_pulse     = node_pulse_q;
    assign busy           = busy_q;
    assign cmd_err        = cmd_err_q;

endmodule

// File: tb/tb_command_executor.sv
// Self-checking bench for command_executor: dispatch vector table, hand-written
// corner sequences, and random command tables against a leg-level reference model.
module tb_command_executor;

    localparam int TURN_C   = 8;
    localparam int UTURN_C  = 16;
    localparam int DEB_C    = 3;
    localparam int BLIND_C  = 5;
    localparam int SETTLE_C = 4;

    logic       clk_50 = 1'b0;
    logic       rst_n  = 1'b0;
    logic [2:0] man_cmd = 3'd0;
    logic       plan_en = 1'b0;
    logic [2:0] plan_tbl [64];
    logic       replan = 1'b0;
    logic       man_node = 1'b0;
    logic       auto_node = 1'b0;
    logic       auto_raw = 1'b0;
    wire  [2:0] robo_cmd;
    wire        node_raw;
    logic [5:0] counter;
    logic [1:0] turn_dir;
    logic       line_follow_en, node_pulse, busy, cmd_err;

    // Planner model: either a command table indexed by counter or a manual value.
    assign robo_cmd = plan_en ? plan_tbl[counter] : man_cmd;
    assign node_raw = auto_node ? auto_raw : man_node;

    command_executor #(
        .TURN_CYCLES(TURN_C), .UTURN_CYCLES(UTURN_C), .DEBOUNCE_CYCLES(DEB_C),
        .BLIND_CYCLES(BLIND_C), .SETTLE_CYCLES(SETTLE_C)
    ) dut (
        .clk_50(clk_50), .rst_n(rst_n), .robo_command(robo_cmd), .replan(replan),
        .node_raw(node_raw), .counter(counter), .turn_dir(turn_dir),
        .line_follow_en(line_follow_en), .node_pulse(node_pulse), .busy(busy),
        .cmd_err(cmd_err)
    );

    always #5 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Track driver: raises the node sensor a while after the follower is enabled.
    int drv_delay = 6, drv_len = 4, drv_hold = 0, lfe_run = 0;
    always @(negedge clk_50) begin
        if (!auto_node) begin
            auto_raw = 1'b0; drv_hold = 0; lfe_run = 0;
        end else begin
            lfe_run = line_follow_en ? lfe_run + 1 : 0;
            if (drv_hold > 0) begin
                drv_hold--;
                if (drv_hold == 0) auto_raw = 1'b0;
            end else if (line_follow_en && lfe_run == drv_delay) begin
                auto_raw = 1'b1; drv_hold = drv_len;
            end
        end
    end

    // Monitor: logs counter at each node pulse and each contiguous turn run.
    logic [5:0] pulse_ctr [$];
    int tlog_dir [$];
    int tlog_len [$];
    int run_dir = 0, run_len = 0;
    always @(negedge clk_50) begin
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (node_pulse) pulse_ctr.push_back(counter);
            if (turn_dir != 2'b00) begin
                if (run_len != 0 && int'(turn_dir) != run_dir) begin
                    tlog_dir.push_back(run_dir); tlog_len.push_back(run_len); run_len = 0;
                end
                run_dir = int'(turn_dir); run_len++;
            end else if (run_len != 0) begin
                tlog_dir.push_back(run_dir); tlog_len.push_back(run_len); run_len = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_50);
        rst_n = 1'b0; auto_node = 1'b0; plan_en = 1'b0;
        man_cmd = 3'd0; man_node = 1'b0; replan = 1'b0;
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        @(negedge clk_50);
    endtask

    function automatic int ref_dir(input int c);
        case (c)
            2: return 1;
            3: return 2;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_len(input int c);
        return (c == 4) ? UTURN_C : TURN_C;
    endfunction

    typedef struct {
        logic [2:0] cmd;
        logic [1:0] dir;
        logic       lfe;
        logic       bsy;
        logic       err;
        int         tlen;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int pb, tb_, n, L, term, nexp;
        bit done;
        int exp_d [$];
        int exp_l [$];

        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pb, tb_, n, L, term;
        bit done;
        int exp_d [$];
        int exp_l [$];

        vecs[0] = '{3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{3'd1, 2'b00, 1'b1, 1'b1, 1'b0, 0};
        vecs[2] = '{3'd2, 2'b01, 1'b0, 1'b1, 1'b0, TURN_C};
        vecs[3] = '{3'd3, 2'b10, 1'b0, 1'b1, 1'b0, TURN_C};
        vecs[4] = '{3'd4, 2'b11, 1'b0, 1'b1, 1'b0, UTURN_C};
        vecs[5] = '{3'd5, 2'b00, 1'b0, 1'b0, 1'b1, 0};
        vecs[6] = '{3'd6, 2'b00, 1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{3'd7, 2'b00, 1'b0, 1'b0, 1'b1, 0};
        for (int k = 0; k < 64; k++) plan_tbl[k] = 3'd0;

        // Reset state
        do_reset();
        chk("rst_counter", int'(counter), 0);
        chk("rst_turn_dir", int'(turn_dir), 0);
        chk("rst_lfe", int'(line_follow_en), 0);
        chk("rst_node_pulse", int'(node_pulse), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);

        // Dispatch table: outputs one cycle after sampling, and turn duration
        for (int i = 0; i < 8; i++) begin
            do_reset();
            man_cmd = vecs[i].cmd;
            @(negedge clk_50);
            man_cmd = 3'd0;
            chk("vec_turn_dir", int'(turn_dir), int'(vecs[i].dir));
            chk("vec_lfe", int'(line_follow_en), int'(vecs[i].lfe));
            chk("vec_busy", int'(busy), int'(vecs[i].bsy));
            chk("vec_cmd_err", int'(cmd_err), int'(vecs[i].err));
            chk("vec_counter", int'(counter), 0);
            if (vecs[i].tlen > 0) begin
                n = 1;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk_50);
                    if (turn_dir == vecs[i].dir) n++;
                    else break;
                end
                chk("vec_turn_len", n, vecs[i].tlen);
                chk("vec_after_turn_lfe", int'(line_follow_en), 1);
            end
            $display("vec %0d cmd=%0d turn_dir=%0d lfe=%0d busy=%0d err=%0d",
                     i, vecs[i].cmd, turn_dir, line_follow_en, busy, cmd_err);
        end

        // Straight leg with node held high for 10 cycles after blind expiry
        do_reset();
        man_cmd = 3'd1;
        @(negedge clk_50);
        man_cmd = 3'd0;
        chk("straight_lfe", int'(line_follow_en), 1);
        repeat (BLIND_C + 1) @(negedge clk_50);
        pb = pulse_ctr.size();
        man_node = 1'b1;
        repeat (10) @(negedge clk_50);
        man_node = 1'b0;
        repeat (8) @(negedge clk_50);
        chk("straight_pulses", pulse_ctr.size() - pb, 1);
        chk("straight_counter", int'(counter), 1);
        chk("straight_busy", int'(busy), 0);
        chk("straight_lfe_off", int'(line_follow_en), 0);
        $display("straight leg: pulses=%0d counter=%0d", pulse_ctr.size() - pb, counter);

        // Blind window, glitch rejection, then a stable node
        do_reset();
        pb = pulse_ctr.size();
        man_node = 1'b1;
        repeat (2) @(negedge clk_50);
        man_cmd = 3'd1;
        @(negedge clk_50);
        man_cmd = 3'd0;
        @(negedge clk_50);
        man_node = 1'b0;
        repeat (12) @(negedge clk_50);
        chk("blind_no_pulse", pulse_ctr.size() - pb, 0);
        chk("blind_counter", int'(counter), 0);
        chk("blind_lfe", int'(line_follow_en), 1);
        man_node = 1'b1;
        repeat (2) @(negedge clk_50);
        man_node = 1'b0;
        repeat (12) @(negedge clk_50);
        chk("glitch_no_pulse", pulse_ctr.size() - pb, 0);
        chk("glitch_lfe", int'(line_follow_en), 1);
        man_node = 1'b1;
        repeat (4) @(negedge clk_50);
        man_node = 1'b0;
        repeat (8) @(negedge clk_50);
        chk("stable_pulse", pulse_ctr.size() - pb, 1);
        chk("stable_counter", int'(counter), 1);
        $display("blind/debounce: pulses=%0d counter=%0d", pulse_ctr.size() - pb, counter);

        // End of leg at counter 3, then replan with a stale command held
        do_reset();
        plan_tbl[0] = 3'd1; plan_tbl[1] = 3'd1; plan_tbl[2] = 3'd1; plan_tbl[3] = 3'd0;
        drv_delay = 3; drv_len = 4;
        pb = pulse_ctr.size();
        plan_en = 1'b1; auto_node = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk_50);
            if (pulse_ctr.size() - pb >= 3 && !busy) done = 1'b1;
        end
        chk("eol_done", int'(done), 1);
        repeat (8) @(negedge clk_50);
        chk("eol_counter", int'(counter), 3);
        chk("eol_busy", int'(busy), 0);
        chk("eol_lfe", int'(line_follow_en), 0);
        plan_en = 1'b0; auto_node = 1'b0; man_cmd = 3'd2; replan = 1'b1;
        @(negedge clk_50);
        replan = 1'b0;
        chk("replan_counter", int'(counter), 0);
        chk("replan_turn0", int'(turn_dir), 0);
        for (int k = 1; k <= SETTLE_C; k++) begin
            @(negedge clk_50);
            chk("replan_settle", int'(turn_dir), 0);
        end
        @(negedge clk_50);
        chk("replan_dispatch", int'(turn_dir), 1);
        man_cmd = 3'd0;
        $display("replan: counter=%0d turn_dir=%0d", counter, turn_dir);

        // Invalid command then asynchronous reset mid-turn
        do_reset();
        man_cmd = 3'd6;
        @(negedge clk_50);
        man_cmd = 3'd2;
        @(negedge clk_50);
        man_cmd = 3'd0;
        chk("inv_err", int'(cmd_err), 1);
        chk("inv_then_turn", int'(turn_dir), 1);
        repeat (2) @(negedge clk_50);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_counter", int'(counter), 0);
        chk("arst_turn_dir", int'(turn_dir), 0);
        chk("arst_lfe", int'(line_follow_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_cmd_err", int'(cmd_err), 0);
        chk("arst_node_pulse", int'(node_pulse), 0);
        @(negedge clk_50);
        rst_n = 1'b1;
        $display("async reset: counter=%0d turn_dir=%0d err=%0d", counter, turn_dir, cmd_err);

        // Saturation: 66 straight advances
        do_reset();
        for (int k = 0; k < 64; k++) plan_tbl[k] = 3'd1;
        drv_delay = 1; drv_len = 4;
        pb = pulse_ctr.size();
        plan_en = 1'b1; auto_node = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk_50);
            if (pulse_ctr.size() - pb >= 66) done = 1'b1;
        end
        chk("sat_done", int'(done), 1);
        if (done) begin
            for (int k = 0; k < 66; k++)
                chk("sat_counter", int'(pulse_ctr[pb + k]), (k + 1 > 63) ? 63 : k + 1);
        end
        chk("sat_final", int'(counter), 63);
        $display("saturation: pulses=%0d counter=%0d", pulse_ctr.size() - pb, counter);

        // Random command tables against the leg-level model
        for (int it = 0; it < 8; it++) begin
            do_reset();
            L = $urandom_range(1, 5);
            for (int k = 0; k < 64; k++) plan_tbl[k] = 3'd0;
            exp_d.delete(); exp_l.delete();
            for (int k = 0; k < L; k++) begin
                plan_tbl[k] = 3'($urandom_range(1, 4));
                if (plan_tbl[k] >= 3'd2) begin
                    exp_d.push_back(ref_dir(int'(plan_tbl[k])));
                    exp_l.push_back(ref_len(int'(plan_tbl[k])));
                end
            end
            term = $urandom_range(0, 3);
            term = (term == 0) ? 0 : term + 4;
            plan_tbl[L] = 3'(term);
            drv_delay = $urandom_range(1, 9);
            drv_len = $urandom_range(4, 6);
            pb = pulse_ctr.size();
            tb_ = tlog_dir.size();
            plan_en = 1'b1; auto_node = 1'b1;
            done = 1'b0;
            for (int c = 0; c < 800 && !done; c++) begin
                @(negedge clk_50);
                if (pulse_ctr.size() - pb >= L && !busy) done = 1'b1;
            end
            repeat (6) @(negedge clk_50);
            chk("rand_done", int'(done), 1);
            chk("rand_pulses", pulse_ctr.size() - pb, L);
            chk("rand_counter", int'(counter), L);
            chk("rand_busy", int'(busy), 0);
            chk("rand_cmd_err", int'(cmd_err), (term != 0) ? 1 : 0);
            chk("rand_turns", tlog_dir.size() - tb_, exp_d.size());
            for (int k = 0; k < exp_d.size() && tb_ + k < tlog_dir.size(); k++) begin
                chk("rand_turn_dir", tlog_dir[tb_ + k], exp_d[k]);
                chk("rand_turn_len", tlog_len[tb_ + k], exp_l[k]);
            end
            for (int k = 0; k < L && pb + k < pulse_ctr.size(); k++)
                chk("rand_pulse_ctr", int'(pulse_ctr[pb + k]), k + 1);
            $display("rand %0d: legs=%0d term=%0d counter=%0d err=%0d turns=%0d",
                     it, L, term, counter, cmd_err, tlog_dir.size() - tb_);
        end

        auto_node = 1'b0; plan_en = 1'b0;
        repeat (2) @(negedge clk_50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
